// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: tick-paced manual / round-robin ADC conversion scheduler
// with a per-channel result register file, timeout and overrun tracking.
module adc_scan_sequencer #(
    parameter int CLK_DIV = 50000,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        scan_en_i,
    input  logic [7:0]  chan_mask_i,
    input  logic [2:0]  manual_chan_i,
    output logic        adc_start_o,
    output logic [2:0]  adc_chan_o,
    input  logic        adc_done_i,
    input  logic [11:0] adc_result_i,
    input  logic [2:0]  rd_chan_i,
    output logic [11:0] rd_data_o,
    output logic [7:0]  rd_valid_o,
    output logic        sample_strobe_o,
    output logic [2:0]  sample_chan_o,
    output logic [11:0] sample_data_o,
    output logic        timeout_err_o,
    output logic [7:0]  missed_ticks_o
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STORE} state_t;
    state_t        state_q;
    logic [CW-1:0] div_q;
    logic [15:0]   to_q;
    logic [2:0]    ptr_q, chan_q, schan_q, scan_chan_d, c;
    logic [11:0]   regs_q [8];
    logic [11:0]   sdata_q;
    logic [7:0]    valid_q, missed_q;
    logic          start_q, strobe_q, terr_q, found_d, tick;
    assign tick = div_q == CW'(CLK_DIV - 1);
    // First enabled channel strictly after the pointer, wrapping back onto it.
    always_comb begin
        found_d = 1'b0;
        scan_chan_d = ptr_q;
        c = ptr_q;
        for (int i = 1; i <= 8; i++) begin
            c = ptr_q + 3'(i);
            if (!found_d && chan_mask_i[c]) begin
                found_d = 1'b1;
                scan_chan_d = c;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            to_q     <= '0;
            ptr_q    <= 3'd7;
            chan_q   <= '0;
            start_q  <= 1'b0;
            valid_q  <= '0;
            strobe_q <= 1'b0;
            schan_q  <= '0;
            sdata_q  <= '0;
            terr_q   <= 1'b0;
            missed_q <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            div_q    <= tick ? '0 : div_q + CW'(1);
            start_q  <= 1'b0;
            strobe_q <= 1'b0;
            if (tick && state_q != S_IDLE && missed_q != 8'hff) missed_q <= missed_q + 8'd1;
            case (state_q)
                S_IDLE: if (tick && (!scan_en_i || found_d)) begin
                    chan_q  <= scan_en_i ? scan_chan_d : manual_chan_i;
                    ptr_q   <= scan_en_i ? scan_chan_d : ptr_q;
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    to_q    <= '0;
                    state_q <= S_WAIT;
                end
                // The result is written on entry to STORE so it is readable alongside the strobe.
                S_WAIT: if (adc_done_i) begin
                    regs_q[chan_q]  <= adc_result_i;
                    valid_q[chan_q] <= 1'b1;
                    schan_q         <= chan_q;
                    sdata_q         <= adc_result_i;
                    strobe_q        <= 1'b1;
                    state_q         <= S_STORE;
                end else if (to_q + 16'd1 == 16'(TIMEOUT - 1)) begin
                    terr_q  <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    to_q <= to_q + 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign adc_start_o     = start_q;
    assign adc_chan_o      = chan_q;
    assign rd_data_o       = regs_q[rd_chan_i];
    assign rd_valid_o      = valid_q;
    assign sample_strobe_o = strobe_q;
    assign sample_chan_o   = schan_q;
    assign sample_data_o   = sdata_q;
    assign timeout_err_o   = terr_q;
    assign missed_ticks_o  = missed_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, overrun unit.
module tb_adc_scan_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic expired(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event never arrived within its cycle budget", nm);
    endtask

    // ---------------- main DUT: CLK_DIV=16, TIMEOUT=8 ----------------
    logic        reset = 1'b1, scan_en = 1'b0, adc_done = 1'b0;
    logic [7:0]  chan_mask = 8'h00;
    logic [2:0]  manual_chan = 3'd0, rd_chan = 3'd0;
    logic [11:0] adc_result = 12'h000;
    logic        adc_start, sample_strobe, timeout_err;
    logic [2:0]  adc_chan, sample_chan;
    logic [11:0] rd_data, sample_data;
    logic [7:0]  rd_valid, missed_ticks;
    int          delay = 5;
    bit          spur = 1'b0;

    adc_scan_sequencer #(.CLK_DIV(16), .TIMEOUT(8)) dut (
        .clk_i(clk), .reset_i(reset), .scan_en_i(scan_en), .chan_mask_i(chan_mask),
        .manual_chan_i(manual_chan), .adc_start_o(adc_start), .adc_chan_o(adc_chan),
        .adc_done_i(adc_done), .adc_result_i(adc_result), .rd_chan_i(rd_chan),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .sample_strobe_o(sample_strobe),
        .sample_chan_o(sample_chan), .sample_data_o(sample_data),
        .timeout_err_o(timeout_err), .missed_ticks_o(missed_ticks)
    );

    // ADC responder: answers `delay` cycles after adc_start (0 = never), optional stray pulses.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    adc_done = 1'b1;
                    adc_result = 12'h100 + 12'(adc_chan);
                end
            end else if (spur && $urandom_range(0, 40) == 0) begin
                adc_done = 1'b1;
                adc_result = 12'($urandom);
            end
            if (adc_start) cd = delay;
        end
    end

    // Reference model in terms of cycle timestamps: conversion starts at cycle S,
    // result may arrive in cycles S+1..S+7, stored the cycle after, idle after that.
    int          n = 0, m_cnt = 0, m_S = 0, m_D = -1, m_missed = 0;
    bit          m_conv = 0, m_start = 0, m_strobe = 0, m_terr = 0;
    logic [2:0]  m_chan = 0, m_ptr = 7, m_schan = 0;
    logic [11:0] m_sdata = 0;
    logic [11:0] m_regs [8] = '{default: 12'h0};
    logic [7:0]  m_valid = 0;

    always @(posedge clk) begin
        bit tick, busy, found;
        if (reset) begin
            m_cnt = 0; m_conv = 0; m_start = 0; m_strobe = 0; m_terr = 0;
            m_chan = 0; m_ptr = 7; m_schan = 0; m_sdata = 0; m_valid = 0; m_missed = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
        end else begin
            tick = (m_cnt == 15);
            m_cnt = (m_cnt + 1) % 16;
            busy = m_conv;
            m_start = 0;
            m_strobe = 0;
            if (m_conv) begin
                if (m_D >= 0) m_conv = (n != m_D + 1);
                else if (n > m_S) begin
                    if (adc_done) begin
                        m_D = n;
                        m_regs[m_chan] = adc_result;
                        m_valid[m_chan] = 1'b1;
                        m_schan = m_chan;
                        m_sdata = adc_result;
                        m_strobe = 1;
                    end else if (n == m_S + 7) begin
                        m_terr = 1;
                        m_conv = 0;
                    end
                end
            end
            if (tick && busy) m_missed = (m_missed < 255) ? m_missed + 1 : 255;
            else if (tick) begin
                found = !scan_en;
                if (!scan_en) m_chan = manual_chan;
                for (int k = 1; k <= 8 && scan_en && !found; k++)
                    if (chan_mask[(m_ptr + k) % 8]) begin
                        found = 1;
                        m_chan = 3'((m_ptr + k) % 8);
                        m_ptr = m_chan;
                    end
                if (found) begin
                    m_conv = 1; m_S = n + 1; m_D = -1; m_start = 1;
                end
            end
        end
        n++;
        #1;
        chk("adc_start", adc_start, m_start);
        chk("adc_chan", adc_chan, m_chan);
        chk("rd_data", rd_data, m_regs[rd_chan]);
        chk("rd_valid", rd_valid, m_valid);
        chk("sample_strobe", sample_strobe, m_strobe);
        chk("sample_chan", sample_chan, m_schan);
        chk("sample_data", sample_data, m_sdata);
        chk("timeout_err", timeout_err, m_terr);
        chk("missed_ticks", missed_ticks, m_missed);
    end

    task automatic wait_start(input string nm, output logic [2:0] ch, output int k);
        ch = 0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (adc_start) begin
                ch = adc_chan;
                return;
            end
        end
        expired(nm);
    endtask

    task automatic wait_strobe(input string nm);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sample_strobe) return;
        end
        expired(nm);
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    // ---------------- overrun DUT: CLK_DIV=16, TIMEOUT=65535 ----------------
    logic        s_reset = 1'b1, s_done = 1'b0, s_fin = 1'b0;
    logic        s_scan = 1'b0;
    logic [7:0]  s_mask = 8'h00;
    logic [2:0]  s_manual = 3'd3, s_rdch = 3'd0;
    logic [11:0] s_result = 12'h000;
    logic        s_start, s_strobe, s_terr;
    logic [2:0]  s_chan, s_schan;
    logic [11:0] s_rdata, s_sdata;
    logic [7:0]  s_valid, s_missed;
    int          s_delay = 40;

    adc_scan_sequencer #(.CLK_DIV(16), .TIMEOUT(65535)) dut_s (
        .clk_i(clk), .reset_i(s_reset), .scan_en_i(s_scan), .chan_mask_i(s_mask),
        .manual_chan_i(s_manual), .adc_start_o(s_start), .adc_chan_o(s_chan),
        .adc_done_i(s_done), .adc_result_i(s_result), .rd_chan_i(s_rdch),
        .rd_data_o(s_rdata), .rd_valid_o(s_valid), .sample_strobe_o(s_strobe),
        .sample_chan_o(s_schan), .sample_data_o(s_sdata),
        .timeout_err_o(s_terr), .missed_ticks_o(s_missed)
    );

    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            s_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    s_done = 1'b1;
                    s_result = 12'h100 + 12'(s_chan);
                end
            end
            if (s_start) cd = s_delay;
        end
    end

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        s_reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 4) s_delay = 4000;
            got = 0;
            for (int k = 0; k < 5000 && !got; k++) begin
                @(negedge clk);
                got = s_strobe;
            end
            if (!got) expired("ovr_strobe");
            chk("ovr_missed", s_missed, (i <= 3) ? 2 * i : 255);
            chk("ovr_data", s_sdata, 12'h103);
        end
        chk("ovr_no_timeout", s_terr, 0);
        s_fin = 1'b1;
    end

    // ---------------- directed + random stimulus for the main DUT ----------------
    initial begin
        logic [2:0] ch;
        int k, starts, strobes;
        int order [5] = '{0, 2, 7, 0, 2};
        repeat (3) @(negedge clk);
        chk("rst_adc_start", adc_start, 0);
        chk("rst_adc_chan", adc_chan, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_strobe", sample_strobe, 0);
        chk("rst_sample_data", sample_data, 0);
        chk("rst_missed", missed_ticks, 0);

        // manual conversion of channel 5; first tick 15 cycles after reset
        manual_chan = 3'd5;
        rd_chan = 3'd5;
        reset = 1'b0;
        wait_start("t1_start", ch, k);
        chk("t1_latency", k, 16);
        chk("t1_chan", ch, 5);
        wait_strobe("t1_strobe");
        chk("t1_sample_chan", sample_chan, 5);
        chk("t1_sample_data", sample_data, 12'h105);
        chk("t1_rd_data", rd_data, 12'h105);
        chk("t1_rd_valid", rd_valid, 8'h20);

        // round-robin over 0,2,7
        pulse_reset();
        scan_en = 1'b1;
        chan_mask = 8'b1000_0101;
        for (int i = 0; i < 5; i++) begin
            wait_start("t2_start", ch, k);
            chk("t2_order", ch, order[i]);
            if (i == 2) begin
                wait_strobe("t2_strobe");
                chk("t2_rd_valid", rd_valid, 8'h85);
            end
        end
        @(negedge clk) chan_mask = 8'h02;
        wait_strobe("t2_strobe_ch2");
        chk("t2_mask_change_chan", sample_chan, 2);
        wait_start("t2_next", ch, k);
        chk("t2_next_chan", ch, 1);
        wait_strobe("t2_strobe_ch1");

        // empty mask: no conversions, nothing missed
        chan_mask = 8'h00;
        starts = 0;
        repeat (80) begin
            @(negedge clk);
            starts += int'(adc_start);
        end
        chk("t3_starts", starts, 0);
        chk("t3_missed", missed_ticks, 0);

        // timeout: ADC never answers
        scan_en = 1'b0;
        manual_chan = 3'd3;
        delay = 0;
        wait_start("t4_start", ch, k);
        strobes = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            strobes += int'(sample_strobe);
            if (j == 7) chk("t4_err_early", timeout_err, 0);
            if (j == 8) chk("t4_err_at_8", timeout_err, 1);
        end
        chk("t4_no_strobe", strobes, 0);
        wait_start("t4_restart", ch, k);
        chk("t4_restart_chan", ch, 3);
        chk("t4_err_sticky", timeout_err, 1);
        delay = 5;
        repeat (12) @(negedge clk);

        // reset in WAIT, result arrives later and must be ignored
        wait_start("t6_start", ch, k);
        repeat (2) @(negedge clk);
        pulse_reset();
        strobes = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            strobes += int'(sample_strobe);
            if (adc_start) break;
        end
        chk("t6_restart_latency", k, 16);
        chk("t6_no_strobe", strobes, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_err_cleared", timeout_err, 0);

        // randomized traffic checked by the model every cycle
        spur = 1'b1;
        repeat (6000) begin
            @(negedge clk);
            rd_chan = 3'($urandom);
            if ($urandom_range(0, 49) == 0) scan_en = ~scan_en;
            if ($urandom_range(0, 29) == 0) chan_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 19) == 0) manual_chan = 3'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 5))
                    0: delay = 0;
                    1: delay = 2;
                    2: delay = 5;
                    3: delay = 7;
                    4: delay = 8;
                    default: delay = 12;
                endcase
            end
            reset = ($urandom_range(0, 1499) == 0);
        end
        reset = 1'b0;
        spur = 1'b0;

        for (int j = 0; j < 20000 && !s_fin; j++) @(negedge clk);
        if (!s_fin) expired("ovr_finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Scheduler for the 8-channel SPI ADC interface. It decides which channel is converted and when, and turns the continuous ADC datapath into periodic, handshaked conversions. Operating modes:
- Manual: the encoder-selected channel only.
- Auto-scan: round-robin over a channel enable mask.
Each result goes into a per-channel register file that the display and other consumers read. Sits between enc2chan/pushbutton logic and the ADC interface in the lab top level.

Parameters:
- CLK_DIV, 50000: clk cycles per conversion tick (1 kHz at 50 MHz); legal range 4..2^20.
- TIMEOUT, 1024: max clk cycles waited in WAIT for adc_done before abort; legal range 2..65535.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- scan_en  in  1  1 = auto-scan over chan_mask; 0 = manual mode
- chan_mask  in  8  auto-scan enable, bit n = channel n
- manual_chan  in  3  channel converted in manual mode
- adc_start  out  1  one-cycle conversion request to ADC interface
- adc_chan  out  3  channel for the current conversion
- adc_done  in  1  one-cycle pulse: adc_result valid
- adc_result  in  12  conversion result
- rd_chan  in  3  register-file read address
- rd_data  out  12  stored result for rd_chan (combinational read)
- rd_valid  out  8  bit n set once channel n has been written since reset
- sample_strobe  out  1  one-cycle pulse on each stored sample
- sample_chan  out  3  channel of last stored sample
- sample_data  out  12  value of last stored sample
- timeout_err  out  1  sticky: a conversion timed out
- missed_ticks  out  8  saturating count of ticks dropped while busy

Behaviour:
Reset (synchronous, reset=1 at posedge):
- All outputs 0: adc_start, adc_chan, rd_valid, sample_*, timeout_err, missed_ticks.
- All 8 stored results cleared to 0.
- Tick counter cleared to 0; FSM to IDLE; round-robin pointer to 7.
- Reset mid-conversion aborts it: nothing stored, no strobe.

Tick generation:
- Free-running counter 0..CLK_DIV-1.
- tick = 1 for one cycle when the counter equals CLK_DIV-1, then it wraps to 0.
- The counter runs in every FSM state.

FSM states: IDLE, START, WAIT, STORE.
- IDLE:
  - On tick with scan_en=0: latch manual_chan into adc_chan, go to START.
  - On tick with scan_en=1 and chan_mask!=0: latch the first set mask bit strictly after the pointer into adc_chan and go to START. Search order is pointer+1 up to 7, then 0 up to the pointer, inclusive. The pointer is updated to the chosen channel.
  - On tick with scan_en=1 and chan_mask==0: stay in IDLE, no conversion, not counted as missed.
- START: adc_start=1 for exactly this cycle. Clear the timeout counter, go to WAIT.
- WAIT:
  - adc_done is sampled only here; pulses in other states are ignored.
  - On adc_done: capture adc_result, go to STORE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without adc_done: set timeout_err, go to IDLE, store nothing.
- STORE (1 cycle):
  - Write the result to regfile[adc_chan] and set rd_valid[adc_chan].
  - Set sample_chan and sample_data; sample_strobe=1 this cycle only.
  - Go to IDLE.
- adc_chan stays stable from START through STORE. Changes to manual_chan, scan_en or chan_mask mid-conversion take effect only at the next IDLE selection.

Latency:
- tick in IDLE at cycle T -> adc_start=1 at T+1.
- adc_done at cycle D -> sample_strobe and updated rd_data at D+1 -> IDLE at D+2.

Overrun:
- A tick in START, WAIT or STORE is dropped and increments missed_ticks, saturating at 255.
- Dropped ticks are not queued.

Read port:
- rd_data = regfile[rd_chan], combinational.
- A read of the channel being written in STORE returns the new value in the same cycle as sample_strobe.

Sticky flags:
- timeout_err and missed_ticks clear only on reset.

Test Plan:
- Bench parameters: CLK_DIV=16, TIMEOUT=8. ADC model answers adc_done 5 cycles after adc_start, with adc_result = 12'h100 + chan.
1. Reset/manual: reset held 3 cycles -> all outputs 0. Then scan_en=0, manual_chan=5 -> adc_start 1 cycle after tick with adc_chan=5; sample_strobe with sample_chan=5, sample_data=12'h105; rd_chan=5 reads 12'h105; rd_valid=8'h20.
2. Round-robin: scan_en=1, chan_mask=8'b1000_0101 -> conversion order 0,2,7,0,2; rd_valid=8'h85 after three samples. Change mask to 8'h02 while WAIT is on ch2 -> ch2 completes, next conversion is ch1.
3. Empty mask: scan_en=1, chan_mask=0 for 5 ticks -> no adc_start, missed_ticks stays 0.
4. Timeout: ADC model never answers -> timeout_err=1 exactly 8 cycles after adc_start; no strobe; next tick starts a new conversion; timeout_err stays 1.
5. Overrun: ADC delay 40 cycles -> missed_ticks increments per dropped tick (2 per conversion); with a 4000-cycle delay and TIMEOUT=65535 it saturates at 255.
6. Reset mid-WAIT: assert reset 2 cycles after adc_start, then a late adc_done -> no store, rd_valid=0, FSM in IDLE, tick counter restarts from 0.
